// File: rtl/pulpino_ext_mailbox_if.sv
// APB bus bundle for the PULPino-side host mailbox.
interface pulpino_ext_mailbox_if #(
  parameter int pAPB_ADDR_WIDTH = 12
);
  logic [pAPB_ADDR_WIDTH-1:0] paddr;
  logic                       psel;
  logic                       penable;
  logic                       pwrite;
  logic [31:0]                pwdata;
  logic [31:0]                prdata;
  logic                       pready;
  logic                       pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/pulpino_ext_mailbox.sv
// PULPino-side host mailbox: APB slave with an RX FIFO filled by host strobes,
// TX data/flags registers driven back to the host, and synchronized host flags.
// Optional macro MAILBOX_IRQ_EN builds the IRQ_EN register and the registered
// level interrupt; without it irq_o is tied low and IRQ_EN reads as zero.
module pulpino_ext_mailbox #(
  parameter int pFIFO_DEPTH     = 4,
  parameter int pAPB_ADDR_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pulpino_ext_mailbox_if.slave apb,
  input  logic [31:0]          ext_data_i,
  input  logic [31:0]          ext_flags_i,
  input  logic                 ext_strobe_i,
  output logic [31:0]          pulpino_data_o,
  output logic [31:0]          pulpino_flags_o,
  output logic                 irq_o
);

  localparam int PW = $clog2(pFIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] REG_RX_DATA  = 3'd0;
  localparam logic [2:0] REG_RX_FLAGS = 3'd1;
  localparam logic [2:0] REG_TX_DATA  = 3'd2;
  localparam logic [2:0] REG_TX_FLAGS = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;
  localparam logic [2:0] REG_IRQ_EN   = 3'd5;

  logic [pAPB_ADDR_WIDTH-1:0] paddr;
  logic [2:0]                 idx;
  logic                       rd_acc, wr_acc;

  assign paddr  = apb.paddr;
  assign idx    = paddr[4:2];
  assign rd_acc = apb.psel & apb.penable & ~apb.pwrite;
  assign wr_acc = apb.psel & apb.penable &  apb.pwrite;

  // Address bits outside [4:2] are intentionally not decoded.
  logic unused_addr;
  assign unused_addr = ^{paddr[pAPB_ADDR_WIDTH-1:5], paddr[1:0]};

  logic [pFIFO_DEPTH-1:0][31:0] mem_q;
  logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                count_q, count_d;
  logic                         strobe_q;
  logic                         overrun_q, overrun_d;
  logic                         empty, full, push, pop, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(pFIFO_DEPTH));
  assign push    = ext_strobe_i & ~strobe_q;
  // A read of an empty FIFO never pops, so empty+push+pop just stores the word.
  assign pop     = rd_acc & (idx == REG_RX_DATA) & ~empty;
  // When full, a same-cycle pop frees the slot the push needs.
  assign push_ok = push & (~full | pop);

  // Next-state for occupancy and the sticky overrun flag (set beats clear).
  always_comb begin
    count_d   = count_q;
    overrun_d = overrun_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (wr_acc && idx == REG_STATUS && apb.pwdata[2]) overrun_d = 1'b0;
    if (push && full && !pop)                         overrun_d = 1'b1;
  end

  // FIFO storage, pointers, strobe edge detector; reset wipes contents too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      strobe_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      strobe_q  <= ext_strobe_i;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= ext_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Two-flop synchronizer for the host flags, which are asynchronous to clk.
  (* ASYNC_REG = "TRUE" *) logic [31:0] flags_meta_q;
  (* ASYNC_REG = "TRUE" *) logic [31:0] flags_sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_meta_q <= '0;
      flags_sync_q <= '0;
    end else begin
      flags_meta_q <= ext_flags_i;
      flags_sync_q <= flags_meta_q;
    end
  end

  // Firmware-written words returned to the host.
  logic [31:0] tx_data_q, tx_flags_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q  <= '0;
      tx_flags_q <= '0;
    end else if (wr_acc) begin
      if (idx == REG_TX_DATA)  tx_data_q  <= apb.pwdata;
      if (idx == REG_TX_FLAGS) tx_flags_q <= apb.pwdata;
    end
  end

  assign pulpino_data_o  = tx_data_q;
  assign pulpino_flags_o = tx_flags_q;

  logic irq_en_rd;
`ifdef MAILBOX_IRQ_EN
  logic irq_en_q, irq_q;
  // Enable bit plus a registered level interrupt for pending RX data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_acc && idx == REG_IRQ_EN) irq_en_q <= apb.pwdata[0];
      irq_q <= irq_en_q & ~empty;
    end
  end
  assign irq_o     = irq_q;
  assign irq_en_rd = irq_en_q;
`else
  assign irq_o     = 1'b0;
  assign irq_en_rd = 1'b0;
`endif

  // Read mux; holes at 0x18/0x1C read as zero.
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    case (idx)
      REG_RX_DATA:  rdata = empty ? 32'd0 : mem_q[rd_ptr_q];
      REG_RX_FLAGS: rdata = flags_sync_q;
      REG_TX_DATA:  rdata = tx_data_q;
      REG_TX_FLAGS: rdata = tx_flags_q;
      REG_STATUS:   rdata = {24'd0, 4'(count_q), 1'b0, overrun_q, full, ~empty};
      REG_IRQ_EN:   rdata = {31'd0, irq_en_rd};
      default:      rdata = '0;
    endcase
  end

  assign apb.prdata  = rd_acc ? rdata : 32'd0;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = apb.psel & apb.penable & (idx > REG_IRQ_EN);

endmodule

// File: tb/tb_pulpino_ext_mailbox.sv
// Directed bench for pulpino_ext_mailbox (depth 4, 12-bit APB address).
module tb_pulpino_ext_mailbox;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ext_data_i = '0;
  logic [31:0] ext_flags_i = '0;
  logic        ext_strobe_i = 1'b0;
  logic [31:0] pulpino_data_o, pulpino_flags_o;
  logic        irq_o;
  int          pass_cnt = 0;
  int          chk_cnt = 0;

  pulpino_ext_mailbox_if #(.pAPB_ADDR_WIDTH(12)) apb();

  pulpino_ext_mailbox #(.pFIFO_DEPTH(4), .pAPB_ADDR_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .apb(apb),
    .ext_data_i(ext_data_i), .ext_flags_i(ext_flags_i), .ext_strobe_i(ext_strobe_i),
    .pulpino_data_o(pulpino_data_o), .pulpino_flags_o(pulpino_flags_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(posedge clk); #1 apb.paddr = a; apb.pwrite = 1'b0; apb.psel = 1'b1; apb.penable = 1'b0;
    @(posedge clk); #1 apb.penable = 1'b1;
    #3 d = apb.prdata; e = apb.pslverr;
    @(posedge clk); #1 apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1 apb.paddr = a; apb.pwdata = d; apb.pwrite = 1'b1; apb.psel = 1'b1; apb.penable = 1'b0;
    @(posedge clk); #1 apb.penable = 1'b1;
    @(posedge clk); #1 apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] d, input int w);
    @(posedge clk); #1 ext_data_i = d; ext_strobe_i = 1'b1;
    repeat (w) @(posedge clk);
    #1 ext_strobe_i = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d; logic e;
    chk_cnt++; if (apb.pready !== 1'b1) $display("FAIL rst_pready got %b exp 1", apb.pready); else pass_cnt++;
    chk_cnt++; if (apb.pslverr !== 1'b0) $display("FAIL rst_pslverr got %b exp 0", apb.pslverr); else pass_cnt++;
    chk_cnt++; if (apb.prdata !== 32'd0) $display("FAIL rst_prdata got %h exp 0", apb.prdata); else pass_cnt++;
    chk_cnt++; if (pulpino_data_o !== 32'd0) $display("FAIL rst_data_o got %h exp 0", pulpino_data_o); else pass_cnt++;
    chk_cnt++; if (pulpino_flags_o !== 32'd0) $display("FAIL rst_flags_o got %h exp 0", pulpino_flags_o); else pass_cnt++;
    chk_cnt++; if (irq_o !== 1'b0) $display("FAIL rst_irq got %b exp 0", irq_o); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      apb_rd(12'(i * 4), d, e);
      chk_cnt++; if (d !== 32'd0 || e !== 1'b0) $display("FAIL rst_reg%0d got %h/%b exp 0/0", i, d, e); else pass_cnt++;
    end
  endtask

  task automatic test_single;
    logic [31:0] d; logic e;
    pulse(32'hDEADBEEF, 3);
    apb_rd(12'h010, d, e);
    chk_cnt++; if (d !== 32'h11) $display("FAIL single_status got %h exp 11", d); else pass_cnt++;
    apb_rd(12'h000, d, e);
    chk_cnt++; if (d !== 32'hDEADBEEF) $display("FAIL single_pop got %h exp deadbeef", d); else pass_cnt++;
    apb_rd(12'h010, d, e);
    chk_cnt++; if (d !== 32'h0) $display("FAIL single_status_after got %h exp 0", d); else pass_cnt++;
  endtask

  task automatic test_overrun;
    logic [31:0] d; logic e;
    for (int i = 1; i <= 5; i++) pulse(32'(i), 1);
    apb_rd(12'h010, d, e);
    chk_cnt++; if (d !== 32'h47) $display("FAIL ovr_status got %h exp 47", d); else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      apb_rd(12'h000, d, e);
      chk_cnt++; if (d !== 32'(i)) $display("FAIL ovr_pop%0d got %h exp %h", i, d, 32'(i)); else pass_cnt++;
    end
    apb_rd(12'h000, d, e);
    chk_cnt++; if (d !== 32'd0 || e !== 1'b0) $display("FAIL ovr_pop_empty got %h/%b exp 0/0", d, e); else pass_cnt++;
    apb_rd(12'h010, d, e);
    chk_cnt++; if (d !== 32'h04) $display("FAIL ovr_sticky got %h exp 04", d); else pass_cnt++;
    apb_wr(12'h010, 32'h4);
    apb_rd(12'h010, d, e);
    chk_cnt++; if (d !== 32'h0) $display("FAIL ovr_clear got %h exp 0", d); else pass_cnt++;
  endtask

  // Pop at 0x00 while a strobe rises in the same access cycle.
  task automatic pop_with_strobe(input logic [31:0] nd, output logic [31:0] d);
    @(posedge clk); #1 apb.paddr = 12'h000; apb.pwrite = 1'b0; apb.psel = 1'b1; apb.penable = 1'b0;
    @(posedge clk); #1 apb.penable = 1'b1; ext_data_i = nd; ext_strobe_i = 1'b1;
    #3 d = apb.prdata;
    @(posedge clk); #1 apb.psel = 1'b0; apb.penable = 1'b0; ext_strobe_i = 1'b0;
  endtask

  task automatic test_full_pop_push;
    logic [31:0] d; logic e;
    for (int i = 0; i < 4; i++) pulse(32'h10 + 32'(i), 1);
    apb_rd(12'h010, d, e);
    chk_cnt++; if (d !== 32'h43) $display("FAIL full_status got %h exp 43", d); else pass_cnt++;
    pop_with_strobe(32'h14, d);
    chk_cnt++; if (d !== 32'h10) $display("FAIL full_pop got %h exp 10", d); else pass_cnt++;
    apb_rd(12'h010, d, e);
    chk_cnt++; if (d !== 32'h43) $display("FAIL full_status2 got %h exp 43", d); else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      apb_rd(12'h000, d, e);
      chk_cnt++; if (d !== 32'h10 + 32'(i)) $display("FAIL full_drain%0d got %h exp %h", i, d, 32'h10 + 32'(i)); else pass_cnt++;
    end
    pop_with_strobe(32'h77, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL empty_pop got %h exp 0", d); else pass_cnt++;
    apb_rd(12'h010, d, e);
    chk_cnt++; if (d !== 32'h11) $display("FAIL empty_status got %h exp 11", d); else pass_cnt++;
    apb_rd(12'h000, d, e);
    chk_cnt++; if (d !== 32'h77) $display("FAIL empty_stored got %h exp 77", d); else pass_cnt++;
  endtask

  task automatic test_tx_rx_flags;
    logic [31:0] d; logic e;
    apb_wr(12'h008, 32'hCAFEF00D);
    chk_cnt++; if (pulpino_data_o !== 32'hCAFEF00D) $display("FAIL tx_data_o got %h exp cafef00d", pulpino_data_o); else pass_cnt++;
    apb_wr(12'h00C, 32'h1);
    chk_cnt++; if (pulpino_flags_o !== 32'h1) $display("FAIL tx_flags_o got %h exp 1", pulpino_flags_o); else pass_cnt++;
    apb_rd(12'h008, d, e);
    chk_cnt++; if (d !== 32'hCAFEF00D) $display("FAIL tx_data_rd got %h exp cafef00d", d); else pass_cnt++;
    // Flags change together with the setup phase: access phase sees only one flop stage.
    @(posedge clk); #1 ext_flags_i = 32'hA5; apb.paddr = 12'h004; apb.pwrite = 1'b0; apb.psel = 1'b1; apb.penable = 1'b0;
    @(posedge clk); #1 apb.penable = 1'b1;
    #3 d = apb.prdata;
    @(posedge clk); #1 apb.psel = 1'b0; apb.penable = 1'b0;
    chk_cnt++; if (d !== 32'h0) $display("FAIL rxflags_early got %h exp 0", d); else pass_cnt++;
    apb_rd(12'h004, d, e);
    chk_cnt++; if (d !== 32'hA5) $display("FAIL rxflags got %h exp a5", d); else pass_cnt++;
  endtask

  task automatic test_irq;
    logic [31:0] d; logic e;
    apb_wr(12'h014, 32'h1);
    apb_rd(12'h014, d, e);
`ifdef MAILBOX_IRQ_EN
    chk_cnt++; if (d !== 32'h1 || e !== 1'b0) $display("FAIL irqen_rd got %h/%b exp 1/0", d, e); else pass_cnt++;
    pulse(32'h55, 1);
    chk_cnt++; if (irq_o !== 1'b0) $display("FAIL irq_lag got %b exp 0", irq_o); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (irq_o !== 1'b1) $display("FAIL irq_high got %b exp 1", irq_o); else pass_cnt++;
    apb_rd(12'h000, d, e);
    chk_cnt++; if (irq_o !== 1'b1) $display("FAIL irq_hold got %b exp 1", irq_o); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (irq_o !== 1'b0) $display("FAIL irq_low got %b exp 0", irq_o); else pass_cnt++;
`else
    chk_cnt++; if (d !== 32'h0 || e !== 1'b0) $display("FAIL irqen_rd got %h/%b exp 0/0", d, e); else pass_cnt++;
    pulse(32'h55, 1);
    repeat (2) @(posedge clk); #1;
    chk_cnt++; if (irq_o !== 1'b0) $display("FAIL irq_tied got %b exp 0", irq_o); else pass_cnt++;
    apb_rd(12'h000, d, e);
`endif
    chk_cnt++; if (d !== 32'h55) $display("FAIL irq_pop got %h exp 55", d); else pass_cnt++;
  endtask

  task automatic test_bad_addr;
    logic [31:0] d; logic e;
    apb_rd(12'h018, d, e);
    chk_cnt++; if (d !== 32'h0 || e !== 1'b1) $display("FAIL bad18 got %h/%b exp 0/1", d, e); else pass_cnt++;
    apb_rd(12'h01C, d, e);
    chk_cnt++; if (d !== 32'h0 || e !== 1'b1) $display("FAIL bad1c got %h/%b exp 0/1", d, e); else pass_cnt++;
    apb_wr(12'h018, 32'hFFFFFFFF);
    apb_rd(12'h008, d, e);
    chk_cnt++; if (d !== 32'hCAFEF00D) $display("FAIL bad_wr_tx got %h exp cafef00d", d); else pass_cnt++;
    apb_rd(12'h010, d, e);
    chk_cnt++; if (d !== 32'h0) $display("FAIL bad_wr_status got %h exp 0", d); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; logic e;
    pulse(32'hA1, 1);
    pulse(32'hA2, 1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk_cnt++; if (pulpino_data_o !== 32'h0 || pulpino_flags_o !== 32'h0) $display("FAIL mid_rst_tx got %h/%h exp 0/0", pulpino_data_o, pulpino_flags_o); else pass_cnt++;
    chk_cnt++; if (irq_o !== 1'b0) $display("FAIL mid_rst_irq got %b exp 0", irq_o); else pass_cnt++;
    @(posedge clk); #1 rst_n = 1'b1;
    apb_rd(12'h010, d, e);
    chk_cnt++; if (d !== 32'h0) $display("FAIL mid_rst_status got %h exp 0", d); else pass_cnt++;
    apb_rd(12'h000, d, e);
    chk_cnt++; if (d !== 32'h0) $display("FAIL mid_rst_rx got %h exp 0", d); else pass_cnt++;
  endtask

  initial begin
    apb.paddr = '0; apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.pwdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset;
    test_single;
    test_overrun;
    test_full_pop_push;
    test_tx_rx_flags;
    test_irq;
    test_bad_addr;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/pulpino_ext_mailbox.md
# pulpino_ext_mailbox

PULPino-side end of the host mailbox: an APB slave peripheral inside the PULPino SoC that receives words pushed by the host-side USB register block and lets firmware return data and flags to the host. Incoming words are captured on the host "data written" strobe into a small RX FIFO, which firmware drains through APB reads. Outgoing data and flag words are firmware-writable registers driven straight back to the host-side block. An optional level interrupt signals pending RX data.

## Interface
Parameters:
- pFIFO_DEPTH, 4: RX FIFO entries; power of two, minimum 2.
- pAPB_ADDR_WIDTH, 12: APB address width; only paddr[4:2] decoded.

Ports:
- clk  in  1  PULPino core clock (same clock as the host block's crypto_clk domain).
- rst_n  in  1  asynchronous, active-low reset.
- paddr  in  pAPB_ADDR_WIDTH  APB address.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  APB write.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data.
- pready  out  1  APB ready.
- pslverr  out  1  APB error.
- ext_data_i  in  32  host-to-PULPino data word (quasi-static).
- ext_flags_i  in  32  host-to-PULPino flags (asynchronous to clk).
- ext_strobe_i  in  1  host "new data" strobe, synchronous to clk, high ≥1 cycle.
- pulpino_data_o  out  32  PULPino-to-host data.
- pulpino_flags_o  out  32  PULPino-to-host flags.
- irq_o  out  1  level interrupt, RX data pending.

## Operation
- Register map (byte offset): 0x00 RX_DATA (RO, pops), 0x04 RX_FLAGS (RO), 0x08 TX_DATA (RW), 0x0C TX_FLAGS (RW), 0x10 STATUS, 0x14 IRQ_EN (RW, bit0). Offsets 0x18–0x1C: pslverr=1, read 0, write ignored.
- STATUS: bit0 rx_valid (count≠0), bit1 rx_full, bit2 overrun (sticky; write 1 clears), bits[7:4] count (zero-extended); other bits 0, other write bits ignored.
- Push: rising edge of ext_strobe_i (ext_strobe_i & ~strobe_q) writes ext_data_i into FIFO at wr_ptr. One push per strobe regardless of width.
- Pop: APB read access (psel & penable & ~pwrite) at 0x00 returns head entry and advances rd_ptr. Read when empty returns 0, no state change, no error.
- Full + push without pop: word dropped, overrun set. Full + push + pop same cycle: both proceed, count stays pDEPTH, no overrun. Empty + push + pop same cycle: pop returns 0, push stored, count→1.
- Pointers are log2(pFIFO_DEPTH) bits and wrap naturally; count is log2(pFIFO_DEPTH)+1 bits.
- RX_FLAGS: ext_flags_i through a 2-flop synchronizer per bit (ASYNC_REG); read returns synchronized value.
- TX_DATA/TX_FLAGS drive pulpino_data_o/pulpino_flags_o directly from the registers.

## Timing
- Reset values: prdata 0, pready 1, pslverr 0, pulpino_data_o 0, pulpino_flags_o 0, irq_o 0; FIFO empty, overrun 0, IRQ_EN 0, strobe_q 0, sync flops 0.
- APB zero wait state: pready constantly 1; prdata/pslverr combinational during access phase; register writes take effect at end of access cycle, visible on outputs next cycle.
- Push: strobe rising at cycle N → entry stored at edge closing N; STATUS.count reflects it from N+1.
- RX_FLAGS latency: 2 clk cycles from a stable ext_flags_i change.
- irq_o registered: irq_o = IRQ_EN[0] & rx_valid, one cycle after either changes.
- Reset asserted mid-operation clears FIFO contents, pointers, and all outputs immediately (asynchronous); no partial push/pop survives.

## Configuration
- MAILBOX_IRQ_EN defined: IRQ_EN register and registered irq_o logic present as above.
- Undefined: irq_o tied 0, IRQ_EN reads 0 and ignores writes (no pslverr), no irq flops built.

## Test plan
- Reset → all registers read 0 except STATUS=0, TX outputs 0, irq_o 0.
- ext_data_i=0xDEADBEEF, 3-cycle strobe → STATUS=0x00000011; RX_DATA read → 0xDEADBEEF, then STATUS=0x0.
- Five strobes with data 1..5 (depth 4) → STATUS=0x00000047; reads return 1,2,3,4, then 0; write 0x4 to STATUS → overrun cleared.
- FIFO full, strobe and RX_DATA read in same cycle → read returns oldest, count stays 4, overrun 0.
- Write TX_DATA=0xCAFEF00D, TX_FLAGS=0x1 → pulpino_data_o/pulpino_flags_o update next cycle; ext_flags_i=0xA5 → RX_FLAGS=0xA5 after 2 cycles.
- MAILBOX_IRQ_EN: IRQ_EN=1, one strobe → irq_o high one cycle after count=1; pop → irq_o low next cycle; read 0x18 → pslverr=1, prdata=0.
